mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single synchronous word-addressed memory port (re/we, 30-bit word address, 32-bit data) between master 0 (CPU-side bus) and master 1 (loader/DMA/debug port).
- Sits between the requesters and the memory.
- Requests are serialised through a 3-state FSM.
- Simultaneous requests are resolved round-robin.
- Each requester gets a registered one-cycle ack plus held read data.

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_req  in  1  master 0 request; held high until m0_ack
m0_we  in  1  master 0 write (1) / read (0); stable while req
m0_addr  in  ADDR_W  master 0 word address; stable while req
m0_wdata  in  DATA_W  master 0 write data; stable while req
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DATA_W  master 0 read data, valid from ack cycle, held until next master 0 read completes
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
busy  out  1  high in ISSUE and WAIT

Behaviour:
- Reset values (any cycle with rst=1, including mid-transaction):
  - state=IDLE.
  - mem_re=mem_we=0; mem_addr=0; mem_wdata=0.
  - m0_ack=m1_ack=0; m0_rdata=m1_rdata=0.
  - last_grant=1, so master 0 wins the first tie.
  - Any in-flight transaction is abandoned with no ack.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Compute eligible requests: mK_req AND NOT mK_ack (masks the master being acked this cycle).
  - None eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the master != last_grant.
  - On a grant, latch owner, we, addr and wdata from the winner; set last_grant=owner; go to ISSUE.
- ISSUE (1 cycle):
  - mem_addr and mem_wdata drive the latched values.
  - mem_re = !we_latched; mem_we = we_latched.
  - Go to WAIT.
- WAIT (1 cycle):
  - mem_re=mem_we=0.
  - On a read, load owner's rdata register from mem_rdata at the clock edge.
  - Set owner's ack register to 1 for the next cycle; go to IDLE.
  - Writes leave rdata unchanged.
- Ack cycle: the cycle after WAIT, in IDLE.
  - Ack is registered and lasts exactly one cycle.
  - The other master can be granted in this same cycle (back-to-back, 3-cycle period).
  - The acked master is re-eligible only one cycle later, so holding req during its ack cycle never double-issues.
- Latency: req sampled in IDLE at cycle N; ISSUE at N+1; WAIT at N+2; ack and rdata at N+3.
- mem_re and mem_we are never both high.
- Both strobes are low outside ISSUE.
- mem_addr and mem_wdata hold the last latched values between transactions.
- Requests raised while busy wait in IDLE for arbitration; there is no queueing inside the block.
- A requester dropping req before its ack is a protocol violation; behaviour is unspecified, except that the transaction already latched completes.

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, WAIT, 2-bit) and the master index constants M0=0, M1=1.
- No sub-module; the round-robin pick is a small combinational function inside the block.

Test Plan:
- Reset then single read: memory holds 0xDEADBEEF at 0x10; m0 read 0x10 at cycle N -> mem_re=1 and mem_addr=0x10 at N+1; m0_ack=1 and m0_rdata=0xDEADBEEF at N+3; m1_ack stays 0.
- Write then read back: m1 writes 0x12345678 to 0x3 -> mem_we=1 at N+1 and m1_ack at N+3, m1_rdata unchanged (0). Then m1 reads 0x3 -> m1_rdata=0x12345678.
- Simultaneous requests after reset: m0 and m1 both read -> m0 granted first with ack at N+3. m1 granted in m0's ack cycle, issues at N+4 and acks at N+6. Next tie is granted to m0.
- Persistent double request: both reqs held high continuously, each dropped one cycle after its ack -> grants strictly alternate m0,m1,m0,m1; no master is acked twice for one request.
- Req held through ack: m0 keeps req high in its ack cycle, m1 idle -> no new ISSUE in the ack cycle. If req is still high one cycle later, a second transaction starts, matching the protocol.
- Reset mid-operation: assert rst during WAIT of an m0 read -> next cycle mem_re=mem_we=0, no m0_ack, m0_rdata=0, state IDLE. After reset, a tie goes to m0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 30;
  localparam int unsigned DEF_DATA_W = 32;

  // Master indices
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Arbiter states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Round-robin pick; on a tie the master that was not granted last wins.
  // Result is don't-care when nothing is eligible.
  function automatic logic rr_pick(input logic [1:0] elig, input logic last_grant);
    if (elig == 2'b11) begin
      return ~last_grant;
    end
    return elig[1] ? M1 : M0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arbiter_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = mem_arbiter_pkg::DEF_DATA_W
) ();

  // Master 0 (CPU-side bus)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  // Master 1 (loader / DMA / debug)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  // Shared memory port
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  // Requester / memory environment side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising two requesters onto one synchronous
// word-addressed memory port. Each access takes IDLE -> ISSUE -> WAIT and
// is acknowledged with a one-cycle registered pulse in the following cycle.
module mem_arbiter #(
  parameter int unsigned ADDR_W = mem_arbiter_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = mem_arbiter_pkg::DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  import mem_arbiter_pkg::*;

  state_t state;
  logic   last_grant;
  logic   owner;
  logic   we_q;

  logic [1:0]        elig_c;
  logic              win_c;
  logic              win_we_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;

  // A master being acked this cycle is masked so a held req cannot double-issue
  assign elig_c = {bus.m1_req & ~bus.m1_ack, bus.m0_req & ~bus.m0_ack};

  // Winner selection and its request fields
  assign win_c       = rr_pick(elig_c, last_grant);
  assign win_we_c    = (win_c == M1) ? bus.m1_we    : bus.m0_we;
  assign win_addr_c  = (win_c == M1) ? bus.m1_addr  : bus.m0_addr;
  assign win_wdata_c = (win_c == M1) ? bus.m1_wdata : bus.m0_wdata;

  // Arbitration FSM with registered memory strobes, acks and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= M1;
      owner         <= M0;
      we_q          <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.m0_ack    <= 1'b0;
      bus.m1_ack    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.m0_ack <= 1'b0;
      bus.m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (|elig_c) begin
            owner         <= win_c;
            last_grant    <= win_c;
            we_q          <= win_we_c;
            bus.mem_addr  <= win_addr_c;
            bus.mem_wdata <= win_wdata_c;
            bus.mem_re    <= ~win_we_c;
            bus.mem_we    <= win_we_c;
            bus.busy      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_re <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (!we_q) begin
            if (owner == M1) begin
              bus.m1_rdata <= bus.mem_rdata;
            end else begin
              bus.m0_rdata <= bus.mem_rdata;
            end
          end
          if (owner == M1) begin
            bus.m1_ack <= 1'b1;
          end else begin
            bus.m0_ack <= 1'b1;
          end
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.mem_re <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed latency/arbitration scenarios plus
// randomized two-master traffic checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int P_REQ   = 0;
  localparam int P_ACKED = 1;
  localparam int P_GAP   = 2;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] mem [256];

  mem_arbiter_if ifc ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Known power-up memory contents; 0x10 holds DEADBEEF
  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEAD_BEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Synchronous memory: read data valid the cycle after mem_re
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (ifc.mem_we) begin
      mem[ifc.mem_addr[7:0]] <= ifc.mem_wdata;
    end
    if (ifc.mem_re) ifc.mem_rdata <= mem[ifc.mem_addr[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int k, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (k == 0) begin
      ifc.m0_req = req; ifc.m0_we = we; ifc.m0_addr = addr; ifc.m0_wdata = wd;
    end else begin
      ifc.m1_req = req; ifc.m1_we = we; ifc.m1_addr = addr; ifc.m1_wdata = wd;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total_cnt++; if ({ifc.mem_re, ifc.mem_we} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {ifc.mem_re, ifc.mem_we}); else pass_cnt++;
    total_cnt++; if (ifc.mem_addr !== '0 || ifc.mem_wdata !== '0) $display("FAIL rst_mem_bus: got addr %h wdata %h want 0", ifc.mem_addr, ifc.mem_wdata); else pass_cnt++;
    total_cnt++; if ({ifc.m0_ack, ifc.m1_ack, ifc.busy} !== 3'b000) $display("FAIL rst_ack_busy: got %b want 000", {ifc.m0_ack, ifc.m1_ack, ifc.busy}); else pass_cnt++;
    total_cnt++; if (ifc.m0_rdata !== '0 || ifc.m1_rdata !== '0) $display("FAIL rst_rdata: got %h %h want 0", ifc.m0_rdata, ifc.m1_rdata); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    set_master(0, 1'b1, 1'b0, 30'h10, 32'h0);
    tick(); // N+1
    total_cnt++; if (ifc.mem_re !== 1'b1 || ifc.mem_we !== 1'b0) $display("FAIL sr_issue_strobe: got re %b we %b want re 1 we 0", ifc.mem_re, ifc.mem_we); else pass_cnt++;
    total_cnt++; if (ifc.mem_addr !== 30'h10) $display("FAIL sr_issue_addr: got %h want 10", ifc.mem_addr); else pass_cnt++;
    total_cnt++; if (ifc.busy !== 1'b1) $display("FAIL sr_busy: got %b want 1", ifc.busy); else pass_cnt++;
    tick(); // N+2
    total_cnt++; if ({ifc.mem_re, ifc.mem_we, ifc.m0_ack} !== 3'b000) $display("FAIL sr_wait: got %b want 000", {ifc.mem_re, ifc.mem_we, ifc.m0_ack}); else pass_cnt++;
    tick(); // N+3
    total_cnt++; if (ifc.m0_ack !== 1'b1 || ifc.m1_ack !== 1'b0) $display("FAIL sr_ack: got m0 %b m1 %b want 1 0", ifc.m0_ack, ifc.m1_ack); else pass_cnt++;
    total_cnt++; if (ifc.m0_rdata !== 32'hDEAD_BEEF) $display("FAIL sr_rdata: got %h want deadbeef", ifc.m0_rdata); else pass_cnt++;
    set_master(0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
    total_cnt++; if (ifc.m0_ack !== 1'b0 || ifc.m0_rdata !== 32'hDEAD_BEEF) $display("FAIL sr_after: got ack %b rdata %h want 0 deadbeef", ifc.m0_ack, ifc.m0_rdata); else pass_cnt++;
  endtask

  task automatic test_write_readback();
    set_master(1, 1'b1, 1'b1, 30'h3, 32'h1234_5678);
    tick();
    total_cnt++; if (ifc.mem_we !== 1'b1 || ifc.mem_re !== 1'b0) $display("FAIL wr_strobe: got we %b re %b want 1 0", ifc.mem_we, ifc.mem_re); else pass_cnt++;
    total_cnt++; if (ifc.mem_addr !== 30'h3 || ifc.mem_wdata !== 32'h1234_5678) $display("FAIL wr_bus: got %h %h want 3 12345678", ifc.mem_addr, ifc.mem_wdata); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (ifc.m1_ack !== 1'b1 || ifc.m1_rdata !== 32'h0) $display("FAIL wr_ack: got ack %b rdata %h want 1 0", ifc.m1_ack, ifc.m1_rdata); else pass_cnt++;
    set_master(1, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
    set_master(1, 1'b1, 1'b0, 30'h3, 32'h0);
    tick(); tick(); tick();
    total_cnt++; if (ifc.m1_ack !== 1'b1 || ifc.m1_rdata !== 32'h1234_5678) $display("FAIL rb_rdata: got ack %b rdata %h want 1 12345678", ifc.m1_ack, ifc.m1_rdata); else pass_cnt++;
    set_master(1, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_master(0, 1'b1, 1'b0, 30'h10, 32'h0);
    set_master(1, 1'b1, 1'b0, 30'h3, 32'h0);
    tick(); // N+1
    total_cnt++; if (ifc.mem_re !== 1'b1 || ifc.mem_addr !== 30'h10) $display("FAIL tie_first: got re %b addr %h want 1 10", ifc.mem_re, ifc.mem_addr); else pass_cnt++;
    tick(); tick(); // N+3
    total_cnt++; if ({ifc.m0_ack, ifc.m1_ack} !== 2'b10 || ifc.m0_rdata !== 32'hDEAD_BEEF) $display("FAIL tie_m0_ack: got acks %b rdata %h want 10 deadbeef", {ifc.m0_ack, ifc.m1_ack}, ifc.m0_rdata); else pass_cnt++;
    set_master(0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick(); // N+4
    total_cnt++; if (ifc.mem_re !== 1'b1 || ifc.mem_addr !== 30'h3) $display("FAIL tie_m1_issue: got re %b addr %h want 1 3", ifc.mem_re, ifc.mem_addr); else pass_cnt++;
    tick(); tick(); // N+6
    total_cnt++; if ({ifc.m0_ack, ifc.m1_ack} !== 2'b01 || ifc.m1_rdata !== 32'h1234_5678) $display("FAIL tie_m1_ack: got acks %b rdata %h want 01 12345678", {ifc.m0_ack, ifc.m1_ack}, ifc.m1_rdata); else pass_cnt++;
    set_master(1, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
    set_master(0, 1'b1, 1'b0, 30'h20, 32'h0);
    set_master(1, 1'b1, 1'b0, 30'h21, 32'h0);
    tick();
    total_cnt++; if (ifc.mem_re !== 1'b1 || ifc.mem_addr !== 30'h20) $display("FAIL tie_second: got re %b addr %h want 1 20", ifc.mem_re, ifc.mem_addr); else pass_cnt++;
    tick(); tick();
    set_master(0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick(); tick(); tick();
    total_cnt++; if (ifc.m1_ack !== 1'b1 || ifc.m1_rdata !== init_val(8'h21)) $display("FAIL tie_second_m1: got ack %b rdata %h want 1 %h", ifc.m1_ack, ifc.m1_rdata, init_val(8'h21)); else pass_cnt++;
    set_master(1, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
  endtask

  task automatic test_req_held();
    set_master(0, 1'b1, 1'b0, 30'h10, 32'h0);
    tick(); tick(); tick(); // N+3 ack, req stays high
    total_cnt++; if (ifc.m0_ack !== 1'b1) $display("FAIL held_ack: got %b want 1", ifc.m0_ack); else pass_cnt++;
    tick(); // N+4
    total_cnt++; if ({ifc.mem_re, ifc.mem_we, ifc.m0_ack} !== 3'b000) $display("FAIL held_no_reissue: got %b want 000", {ifc.mem_re, ifc.mem_we, ifc.m0_ack}); else pass_cnt++;
    tick(); // N+5
    total_cnt++; if (ifc.mem_re !== 1'b1 || ifc.mem_addr !== 30'h10) $display("FAIL held_second_issue: got re %b addr %h want 1 10", ifc.mem_re, ifc.mem_addr); else pass_cnt++;
    tick(); tick(); // N+7
    total_cnt++; if (ifc.m0_ack !== 1'b1) $display("FAIL held_second_ack: got %b want 1", ifc.m0_ack); else pass_cnt++;
    set_master(0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    set_master(0, 1'b1, 1'b0, 30'h10, 32'h0);
    tick(); tick(); // WAIT
    rst = 1'b1;
    tick();
    total_cnt++; if ({ifc.mem_re, ifc.mem_we, ifc.m0_ack, ifc.busy} !== 4'b0000) $display("FAIL mid_rst_ctrl: got %b want 0000", {ifc.mem_re, ifc.mem_we, ifc.m0_ack, ifc.busy}); else pass_cnt++;
    total_cnt++; if (ifc.m0_rdata !== '0) $display("FAIL mid_rst_rdata: got %h want 0", ifc.m0_rdata); else pass_cnt++;
    rst = 1'b0;
    set_master(0, 1'b1, 1'b0, 30'h30, 32'h0);
    set_master(1, 1'b1, 1'b0, 30'h31, 32'h0);
    tick();
    total_cnt++; if (ifc.mem_re !== 1'b1 || ifc.mem_addr !== 30'h30) $display("FAIL mid_rst_tie: got re %b addr %h want 1 30", ifc.mem_re, ifc.mem_addr); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (ifc.m0_ack !== 1'b1 || ifc.m0_rdata !== init_val(8'h30)) $display("FAIL mid_rst_m0: got ack %b rdata %h want 1 %h", ifc.m0_ack, ifc.m0_rdata, init_val(8'h30)); else pass_cnt++;
    set_master(0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick(); tick(); tick();
    set_master(1, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
  endtask

  // Randomized traffic; contend=1 keeps both masters requesting back to back
  task automatic test_traffic(input bit contend, input int n_cycles);
    int            phase [2];
    int            gap [2];
    int            age [2];
    logic          we_k [2];
    logic [AW-1:0] addr_k [2];
    logic [DW-1:0] wd_k [2];
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] ref_mem [256];
    logic          last_acked;
    logic          ack_k;
    logic [DW-1:0] rd_k;
    bit            issuing;
    bit            drained;
    int            cyc;

    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int k = 0; k < 2; k++) begin
      phase[k] = P_GAP; gap[k] = 1; age[k] = 0; exp_rd[k] = '0;
      we_k[k] = 1'b0; addr_k[k] = '0; wd_k[k] = '0;
    end
    last_acked = 1'b1;
    drained = 1'b0;
    cyc = 0;

    while (cyc <= n_cycles + 40) begin
      issuing = (cyc < n_cycles);
      if (!issuing && phase[0] == P_GAP && phase[1] == P_GAP) begin
        drained = 1'b1;
        break;
      end
      total_cnt++; if (ifc.mem_re === 1'b1 && ifc.mem_we === 1'b1) $display("FAIL tr_strobes_both: got re %b we %b want not both", ifc.mem_re, ifc.mem_we); else pass_cnt++;
      for (int k = 0; k < 2; k++) begin
        ack_k = (k == 0) ? ifc.m0_ack : ifc.m1_ack;
        rd_k  = (k == 0) ? ifc.m0_rdata : ifc.m1_rdata;
        if (ack_k === 1'b1) begin
          total_cnt++;
          if (phase[k] != P_REQ) begin
            $display("FAIL tr_spurious_ack: master %0d acked in phase %0d want phase %0d", k, phase[k], P_REQ);
          end else begin
            pass_cnt++;
            if (we_k[k]) ref_mem[addr_k[k][7:0]] = wd_k[k];
            else exp_rd[k] = ref_mem[addr_k[k][7:0]];
            total_cnt++; if (rd_k !== exp_rd[k]) $display("FAIL tr_rdata: master %0d got %h want %h", k, rd_k, exp_rd[k]); else pass_cnt++;
            total_cnt++; if (age[k] > 5) $display("FAIL tr_latency: master %0d got %0d want <=5", k, age[k]); else pass_cnt++;
            if (contend) begin
              total_cnt++; if (1'(k) !== ~last_acked) $display("FAIL tr_alternate: got master %0d want %0d", k, ~last_acked); else pass_cnt++;
            end
            last_acked = 1'(k);
            phase[k] = P_ACKED;
          end
        end else if (phase[k] == P_REQ) begin
          age[k]++;
        end else if (phase[k] == P_ACKED) begin
          set_master(k, 1'b0, 1'b0, '0, '0);
          phase[k] = P_GAP;
          gap[k] = contend ? 1 : int'($urandom_range(1, 5));
        end else begin
          if (gap[k] > 0) gap[k]--;
          if (gap[k] == 0 && issuing) begin
            we_k[k]   = 1'($urandom_range(0, 1));
            addr_k[k] = AW'($urandom_range(0, 255));
            wd_k[k]   = $urandom;
            set_master(k, 1'b1, we_k[k], addr_k[k], wd_k[k]);
            age[k]   = 0;
            phase[k] = P_REQ;
          end
        end
      end
      tick();
      cyc++;
    end
    total_cnt++; if (!drained) $display("FAIL tr_drain: got phases %0d %0d want both idle", phase[0], phase[1]); else pass_cnt++;
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    mem_init = 1'b0;

    test_reset();
    test_single_read();
    test_write_readback();
    test_simultaneous();
    test_req_held();
    test_reset_mid();
    test_traffic(1'b1, 300);
    test_traffic(1'b0, 400);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard stop in case the sequence stalls
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
